// File: rtl/butterfly_inverse.sv
// Inverse radix-2 butterfly: rebuilds (a, b) from packed (s, d) = (a+b, a-b) through a
// two-stage valid/ready pipeline. Define BUTTERFLY_INV_ROUND_EN for round-half-up with saturation.
module butterfly_inverse #(
  parameter int WORD_SZ = 8,
  parameter int CNT_W   = 8
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WORD_SZ-1:0] in1,
  input  logic [WORD_SZ-1:0] in2,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_SZ-1:0] out1,
  output logic [WORD_SZ-1:0] out2,
  output logic               o_odd,
  output logic [CNT_W-1:0]   o_count
);

  localparam int HALF = WORD_SZ / 2;

  typedef logic signed [HALF:0] ext_t;

  typedef struct packed {
    ext_t rr_sum;
    ext_t ii_sum;
    ext_t rr_dif;
    ext_t ii_dif;
  } s1_t;

  function automatic ext_t sext(input logic [HALF-1:0] v);
    return ext_t'({v[HALF-1], v});
  endfunction

`ifdef BUTTERFLY_INV_ROUND_EN
  typedef logic signed [HALF+1:0] ext2_t;
  localparam ext2_t HMAX = {3'b000, {(HALF-1){1'b1}}};

  // One extra bit of headroom so the +1 cannot wrap before the shift.
  function automatic logic [HALF-1:0] halve(input ext_t x);
    ext2_t r;
    r = ext2_t'(x) + ext2_t'(1);
    r = r >>> 1;
    if (r > HMAX) return HMAX[HALF-1:0];
    return r[HALF-1:0];
  endfunction
`else
  function automatic logic [HALF-1:0] halve(input ext_t x);
    return x[HALF:1];
  endfunction
`endif

  logic               s1_valid_q, s1_valid_d;
  s1_t                s1_q, s1_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WORD_SZ-1:0] out1_q, out1_d, out2_q, out2_d;
  logic               odd_q, odd_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic s2_load, s1_load, xfer;

  assign s2_load = s1_valid_q && (!s2_valid_q || i_ready);
  assign s1_load = !s1_valid_q || s2_load;
  assign xfer    = s2_valid_q && i_ready;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    odd_d      = odd_q;
    count_d    = count_q;

    if (s1_load) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_d.rr_sum = sext(in1[WORD_SZ-1 -: HALF]) + sext(in2[WORD_SZ-1 -: HALF]);
        s1_d.ii_sum = sext(in1[HALF-1:0])          + sext(in2[HALF-1:0]);
        s1_d.rr_dif = sext(in1[WORD_SZ-1 -: HALF]) - sext(in2[WORD_SZ-1 -: HALF]);
        s1_d.ii_dif = sext(in1[HALF-1:0])          - sext(in2[HALF-1:0]);
      end
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      out1_d     = {halve(s1_q.rr_sum), halve(s1_q.ii_sum)};
      out2_d     = {halve(s1_q.rr_dif), halve(s1_q.ii_dif)};
      odd_d      = s1_q.rr_sum[0] | s1_q.ii_sum[0] | s1_q.rr_dif[0] | s1_q.ii_dif[0];
    end else if (xfer) begin
      s2_valid_d = 1'b0;
    end

    if (xfer) count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only. Data registers are reset
  // as well so the outputs read 0 the moment reset asserts, not just the valid flags.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      out1_q     <= '0;
      out2_q     <= '0;
      odd_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      odd_q      <= odd_d;
      count_q    <= count_d;
    end
  end

  assign o_ready = s1_load;
  assign o_valid = s2_valid_q;
  assign out1    = out1_q;
  assign out2    = out2_q;
  assign o_odd   = odd_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_butterfly_inverse.sv
// Bench for butterfly_inverse: vector table, hand-written stall/reset/wrap sequences and a
// random stream, all checked through an in-order scoreboard.
module tb_butterfly_inverse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0, i_ready = 1'b1;
  logic [7:0] in1 = '0, in2 = '0;
  logic       o_ready, o_valid, o_odd;
  logic [7:0] out1, out2, o_count;

  logic       w_valid = 1'b0, w_ready = 1'b1;
  logic [7:0] w_in1 = 8'h52, w_in2 = 8'h10;
  logic       w_oready, w_ovalid, w_odd;
  logic [7:0] w_out1, w_out2;
  logic [3:0] w_count;

  always #5 clk = ~clk;

  butterfly_inverse #(.WORD_SZ(8), .CNT_W(8)) dut (
    .i_CLK(clk), .i_RESET(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .in1(in1), .in2(in2), .o_valid(o_valid), .i_ready(i_ready),
    .out1(out1), .out2(out2), .o_odd(o_odd), .o_count(o_count)
  );

  butterfly_inverse #(.WORD_SZ(8), .CNT_W(4)) dut_w (
    .i_CLK(clk), .i_RESET(rst_n), .i_valid(w_valid), .o_ready(w_oready),
    .in1(w_in1), .in2(w_in2), .o_valid(w_ovalid), .i_ready(w_ready),
    .out1(w_out1), .out2(w_out2), .o_odd(w_odd), .o_count(w_count)
  );

  typedef struct {
    logic [7:0] in1, in2, e1, e2;
    logic       eodd;
  } vec_t;

  typedef struct {
    logic [7:0] e1, e2;
    logic       eodd;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0, miscompares = 0;
  int   xfers = 0, sent = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Arithmetic reference: floor((s +/- d)/2) per component, or round-half-up with saturation.
  function automatic exp_t model(input logic [7:0] s, input logic [7:0] d);
    exp_t       e;
    int         x[4];
    int         y;
    logic [3:0] r[4];
    x[0] = $signed(s[7:4]) + $signed(d[7:4]);
    x[1] = $signed(s[3:0]) + $signed(d[3:0]);
    x[2] = $signed(s[7:4]) - $signed(d[7:4]);
    x[3] = $signed(s[3:0]) - $signed(d[3:0]);
    e.eodd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e.eodd |= x[k][0];
`ifdef BUTTERFLY_INV_ROUND_EN
      y = (x[k] + 1) >>> 1;
      if (y > 7) y = 7;
`else
      y = x[k] >>> 1;
`endif
      r[k] = y[3:0];
    end
    e.e1 = {r[0], r[1]};
    e.e2 = {r[2], r[3]};
    return e;
  endfunction

  // Scoreboard monitor: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got out1=%0h out2=%0h, expected no output", out1, out2);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_out1", out1, e.e1);
        check("sb_out2", out2, e.e2);
        check("sb_odd", o_odd, e.eodd);
        check("sb_count", o_count, xfers[7:0]);
        xfers++;
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int n = 0;
    in1 = a;
    in2 = b;
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got o_ready=0, expected 1 within 50 cycles");
    end else begin
      sb_q.push_back(e);
      sent++;
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1 check("drain_empty", sb_q.size(), 0);
  endtask

  vec_t tbl[7];
  exp_t e;
  logic [7:0] a, b;

  initial begin
    tbl[0] = '{8'h52, 8'h10, 8'h31, 8'h21, 1'b0};
    tbl[1] = '{8'hE0, 8'h40, 8'h10, 8'hD0, 1'b0};
    tbl[2] = '{8'h70, 8'h70, 8'h70, 8'h00, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
`ifdef BUTTERFLY_INV_ROUND_EN
    tbl[4] = '{8'h30, 8'h00, 8'h20, 8'h20, 1'b1};
    tbl[5] = '{8'h80, 8'h70, 8'h00, 8'h90, 1'b1};
    tbl[6] = '{8'h7F, 8'h80, 8'h00, 8'h70, 1'b1};
`else
    tbl[4] = '{8'h30, 8'h00, 8'h10, 8'h10, 1'b1};
    tbl[5] = '{8'h80, 8'h70, 8'hF0, 8'h80, 1'b1};
    tbl[6] = '{8'h7F, 8'h80, 8'hFF, 8'h7F, 1'b1};
`endif

    // Reset state
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_out1", out1, 0);
    check("rst_out2", out2, 0);
    check("rst_odd", o_odd, 0);
    check("rst_count", o_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_ready", o_ready, 1);

    // First pair: two-cycle latency, then count reaches 1
    @(posedge clk);
    #1;
    drive(tbl[0].in1, tbl[0].in2, '{tbl[0].e1, tbl[0].e2, tbl[0].eodd});
    check("lat_first_s1", o_valid, 0);
    @(posedge clk);
    #1 check("lat_first_s2", o_valid, 1);
    @(posedge clk);
    #1 check("count_first", o_count, 1);

    // Table vectors back-to-back
    for (int i = 1; i < 7; i++)
      drive(tbl[i].in1, tbl[i].in2, '{tbl[i].e1, tbl[i].e2, tbl[i].eodd});
    drain();

    // Back-pressure: two pairs fill the pipe, then o_ready drops while outputs hold
    i_ready = 1'b0;
    drive(8'h12, 8'h34, model(8'h12, 8'h34));
    drive(8'hA5, 8'h3C, model(8'hA5, 8'h3C));
    check("bp_ready_low", o_ready, 0);
    check("bp_valid", o_valid, 1);
    e = model(8'h12, 8'h34);
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_out1", out1, e.e1);
    check("bp_hold_out2", out2, e.e2);
    check("bp_hold_odd", o_odd, e.eodd);
    fork
      begin
        drive(8'h5A, 8'hC3, model(8'h5A, 8'hC3));
        drive(8'h77, 8'h88, model(8'h77, 8'h88));
      end
      begin
        repeat (2) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", o_count, sent);

    // Random stream with random back-pressure
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          a = 8'($urandom);
          b = 8'($urandom);
          drive(a, b, model(a, b));
        end
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
      end
    join
    i_ready = 1'b1;
    drain();
    check("rand_count", o_count, sent & 32'hFF);

    // Reset mid-stream with both stages full
    i_ready = 1'b0;
    drive(8'h52, 8'h10, model(8'h52, 8'h10));
    drive(8'h30, 8'h00, model(8'h30, 8'h00));
    check("mid_valid_before", o_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_out1", out1, 0);
    check("mid_rst_out2", out2, 0);
    check("mid_rst_odd", o_odd, 0);
    check("mid_rst_count", o_count, 0);
    sb_q.delete();
    xfers = 0;
    sent = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    drive(8'hE0, 8'h40, model(8'hE0, 8'h40));
    check("lat_post_s1", o_valid, 0);
    @(posedge clk);
    #1 check("lat_post_s2", o_valid, 1);
    drain();

    // Counter wrap on the 4-bit instance: 17 transfers
    check("wrap_start", w_count, 0);
    w_valid = 1'b1;
    repeat (17) @(posedge clk);
    #1 w_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("wrap_count", w_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

endmodule
